// File: rtl/xup_tff_arb_pkg.sv
// Shared definitions for the TFF vector arbiter: controller states and
// the index-width helper used to size grant/pointer registers.
package xup_tff_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SETTLE = 2'd2,
      ACK    = 2'd3
   } state_t;

   // Bits needed to index n requesters; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/xup_rr_arbiter.sv
// Combinational round-robin search: first set request starting at ptr,
// wrapping modulo NREQ. The pointer itself lives in the caller.
module xup_rr_arbiter
   import xup_tff_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            gvalid,
   output logic [IW-1:0]   gidx
);

   // Priority scan ptr, ptr+1, ... with wrap; the first hit wins.
   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      gvalid = 1'b0;
      gidx   = '0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gvalid && req[idx]) begin
            gvalid = 1'b1;
            gidx   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/xup_tff_vector_arbiter.sv
// Round-robin controller sharing one TFF toggle vector between NREQ
// requesters: grant, pulse t/en for one cycle, capture q, ack one cycle.
module xup_tff_vector_arbiter
   import xup_tff_arb_pkg::*;
#(
   parameter int SIZE = 4,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SIZE-1:0] mask,
   output logic [NREQ-1:0]      ack,
   output logic [SIZE-1:0]      rdata,
   output logic                 busy,
   output logic [SIZE-1:0]      t,
   output logic                 en,
   input  logic [SIZE-1:0]      q_in
);

   localparam int IW = clog2(NREQ);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gidx;
   logic            sel_valid;
   logic [IW-1:0]   sel_idx;
   logic [IW-1:0]   ptr_next;

   xup_rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req    (req),
      .ptr    (ptr),
      .gvalid (sel_valid),
      .gidx   (sel_idx)
   );

   // Pointer moves one past the winner so it becomes lowest priority next.
   assign ptr_next = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;

   // Busy is a pure decode of the state register.
   assign busy = (state != IDLE);

   // Operation sequencer: IDLE -> APPLY -> SETTLE -> ACK -> IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         gidx  <= '0;
         t     <= '0;
         en    <= 1'b0;
         ack   <= '0;
         rdata <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  gidx  <= sel_idx;
                  t     <= mask[sel_idx*SIZE +: SIZE];
                  en    <= 1'b1;
                  ptr   <= ptr_next;
                  state <= APPLY;
               end
            end
            APPLY: begin
               t     <= '0;
               en    <= 1'b0;
               state <= SETTLE;
            end
            SETTLE: begin
               rdata <= q_in;
               ack   <= NREQ'(1) << gidx;
               state <= ACK;
            end
            ACK: begin
               ack   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xup_tff_vector_arbiter.sv
// Self-checking bench for xup_tff_vector_arbiter with a TFF vector model
// and a round-robin reference computed from the grant rules.
module tb_xup_tff_vector_arbiter;

   localparam int SIZE = 4;
   localparam int NREQ = 4;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*SIZE-1:0] mask;
   logic [NREQ-1:0]      ack;
   logic [SIZE-1:0]      rdata;
   logic                 busy;
   logic [SIZE-1:0]      t;
   logic                 en;
   logic [SIZE-1:0]      q_in;

   logic [SIZE-1:0]      q_tff;
   logic                 tff_load;
   logic [SIZE-1:0]      tff_val;

   int checks;
   int errors;
   int ptr_m;
   logic [SIZE-1:0] q_exp;

   xup_tff_vector_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .mask  (mask),
      .ack   (ack),
      .rdata (rdata),
      .busy  (busy),
      .t     (t),
      .en    (en),
      .q_in  (q_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared TFF vector model: toggles masked bits on an enabled edge.
   always @(posedge clk) begin
      if (tff_load) q_tff <= tff_val;
      else if (en)  q_tff <= q_tff ^ t;
   end
   assign q_in = q_tff;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_q(input logic [SIZE-1:0] v);
      @(negedge clk);
      tff_load = 1'b1;
      tff_val  = v;
      @(negedge clk);
      tff_load = 1'b0;
      q_exp    = v;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ptr_m = 0;
   endtask

   task automatic set_mask(input int i, input logic [SIZE-1:0] m);
      mask[i*SIZE +: SIZE] = m;
   endtask

   // One full operation from IDLE with req already driven.
   // drop_mode: 0 = drop at ack, 1 = drop during APPLY, 2 = keep requesting.
   task automatic do_op(input int drop_mode, input string tag);
      int g;
      logic [SIZE-1:0] m;
      logic [SIZE-1:0] exp_rd;
      logic [NREQ-1:0] exp_ack;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         if (g < 0 && req[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      end
      m       = mask[g*SIZE +: SIZE];
      exp_rd  = q_exp ^ m;
      exp_ack = NREQ'(1) << g;

      @(negedge clk);
      checks++;
      if ({en, t, busy, ack} !== {1'b1, m, 1'b1, {NREQ{1'b0}}}) begin
         errors++;
         $display("FAIL %s apply: got en=%b t=%b busy=%b ack=%b, want en=1 t=%b busy=1 ack=0 (grant %0d)",
                  tag, en, t, busy, ack, m, g);
      end
      ptr_m = (g + 1) % NREQ;
      q_exp = exp_rd;
      if (drop_mode == 1) req[g] = 1'b0;

      @(negedge clk);
      checks++;
      if ({en, t, busy, ack} !== {1'b0, {SIZE{1'b0}}, 1'b1, {NREQ{1'b0}}}) begin
         errors++;
         $display("FAIL %s settle: got en=%b t=%b busy=%b ack=%b, want en=0 t=0 busy=1 ack=0",
                  tag, en, t, busy, ack);
      end

      @(negedge clk);
      checks++;
      if ({ack, rdata, busy, en} !== {exp_ack, exp_rd, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s ack: got ack=%b rdata=%b busy=%b en=%b, want ack=%b rdata=%b busy=1 en=0",
                  tag, ack, rdata, busy, en, exp_ack, exp_rd);
      end
      if (drop_mode == 0) req[g] = 1'b0;

      @(negedge clk);
      checks++;
      if ({ack, busy, en, rdata} !== {{NREQ{1'b0}}, 1'b0, 1'b0, exp_rd}) begin
         errors++;
         $display("FAIL %s idle: got ack=%b busy=%b en=%b rdata=%b, want ack=0 busy=0 en=0 rdata=%b",
                  tag, ack, busy, en, rdata, exp_rd);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      req      = '0;
      mask     = '0;
      tff_load = 1'b1;
      tff_val  = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({t, en, ack, rdata, busy} !== '0) begin
         errors++;
         $display("FAIL reset_values: got t=%b en=%b ack=%b rdata=%b busy=%b, want all 0",
                  t, en, ack, rdata, busy);
      end
      tff_load = 1'b0;
      q_exp    = '0;
      reset    = 1'b0;
      ptr_m    = 0;
   endtask

   task automatic test_idle();
      req = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({en, t, busy, ack} !== '0) begin
            errors++;
            $display("FAIL idle_no_req: got en=%b t=%b busy=%b ack=%b, want all 0", en, t, busy, ack);
         end
      end
   endtask

   task automatic test_single();
      set_q(4'b0000);
      set_mask(0, 4'b0101);
      req = 4'b0001;
      do_op(0, "single");
   endtask

   task automatic test_round_robin();
      apply_reset();
      set_q(4'b0000);
      set_mask(0, 4'b0001);
      set_mask(1, 4'b0010);
      set_mask(2, 4'b0100);
      set_mask(3, 4'b1000);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) do_op(2, $sformatf("rr%0d", i));
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_pointer_wrap();
      req = 4'b1000;
      do_op(0, "wrap_g3");
      req = 4'b1001;
      do_op(0, "wrap_first");
      do_op(0, "wrap_second");
   endtask

   task automatic test_zero_mask();
      set_q(4'b1010);
      set_mask(2, 4'b0000);
      req = 4'b0100;
      do_op(0, "zero_mask");
   endtask

   task automatic test_all_ones();
      set_q(4'b0110);
      set_mask(1, 4'b1111);
      req = 4'b0010;
      do_op(0, "all_ones");
   endtask

   task automatic test_withdraw();
      set_mask(1, 4'b0011);
      req = 4'b0010;
      do_op(1, "withdraw");
   endtask

   task automatic test_reset_mid_op();
      set_mask(2, 4'b0011);
      req   = 4'b0100;
      ptr_m = 0;
      @(negedge clk);
      @(negedge clk);
      q_exp = q_exp ^ 4'b0011;
      reset = 1'b1;
      #1;
      checks++;
      if ({t, en, ack, rdata, busy} !== '0) begin
         errors++;
         $display("FAIL reset_mid_op: got t=%b en=%b ack=%b rdata=%b busy=%b, want all 0",
                  t, en, ack, rdata, busy);
      end
      @(negedge clk);
      checks++;
      if ({ack, busy} !== '0) begin
         errors++;
         $display("FAIL reset_no_ack: got ack=%b busy=%b, want 0", ack, busy);
      end
      ptr_m = 0;
      set_mask(3, 4'b1000);
      req   = 4'b1100;
      reset = 1'b0;
      do_op(0, "post_reset_first");
      do_op(0, "post_reset_second");
   endtask

   task automatic test_random();
      logic [NREQ-1:0] newreq;
      for (int n = 0; n < 60; n++) begin
         newreq = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && newreq[i]) set_mask(i, SIZE'($urandom));
         end
         req = req | newreq;
         if (req == '0) begin
            @(negedge clk);
            checks++;
            if ({en, busy, ack} !== '0) begin
               errors++;
               $display("FAIL rand_idle: got en=%b busy=%b ack=%b, want 0", en, busy, ack);
            end
         end else begin
            do_op(int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
         end
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_idle();
      test_single();
      test_round_robin();
      test_pointer_wrap();
      test_zero_mask();
      test_all_ones();
      test_withdraw();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
